// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// and the store-lane alignment / legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    WB,
    FIN
  } lsu_state_t;

  typedef struct packed {
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } store_lane_t;

  // Byte enables follow the offset; data is replicated so every lane carries it.
  function automatic store_lane_t store_align(input logic [2:0]  funct3,
                                              input logic [1:0]  off,
                                              input logic [31:0] wdata);
    store_lane_t s;
    s.wstrb = '0;
    s.wdata = wdata;
    case (funct3)
      F3_SB: begin
        s.wstrb = 4'b0001 << off;
        s.wdata = {4{wdata[7:0]}};
      end
      F3_SH: begin
        s.wstrb = 4'b0011 << off;
        s.wdata = {2{wdata[15:0]}};
      end
      F3_SW: begin
        s.wstrb = 4'b1111;
        s.wdata = wdata;
      end
      default: ;
    endcase
    return s;
  endfunction

  function automatic logic op_legal(input logic store, input logic [2:0] funct3);
    if (store)
      return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    else
      return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
             (funct3 == F3_LBU) || (funct3 == F3_LHU);
  endfunction

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic op_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    return ((funct3[1:0] == 2'b01) && off[0]) ||
           ((funct3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Word-addressed data-memory port: valid/ready request channel plus rvalid response.
interface lsu_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic            mem_ready;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_wstrb;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load-data extraction: selects the byte/half by offset and
// sign- or zero-extends according to funct3.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{off, 3'b000} +: 8];
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Multi-cycle RV32I load/store unit: one operation at a time, aligned store
// lanes, extended load data written back to the register file.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic            op_store,
  input  logic [2:0]      op_funct3,
  input  logic [XLEN-1:0] op_addr,
  input  logic [XLEN-1:0] op_wdata,
  input  logic [4:0]      op_rd,
  output logic            done,
  output logic            err,
  lsu_if.master           mem,
  output logic            wb_en,
  output logic [4:0]      wb_reg,
  output logic [XLEN-1:0] wb_data
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  lsu_state_t      state_q, state_d;
  logic            store_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic [4:0]      rd_q;
  logic            err_q;
  logic [XLEN-1:0] addr_q;
  logic [3:0]      wstrb_q;
  logic [XLEN-1:0] wdata_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] wb_data_q;
  logic [XLEN-1:0] ld_data;
  logic            op_bad;
  logic            accept;
  logic            timeout;
  store_lane_t     lane;

  always_comb begin
    lane    = store_align(op_funct3, op_addr[1:0], op_wdata);
    op_bad  = !op_legal(op_store, op_funct3) || op_misaligned(op_funct3, op_addr[1:0]);
    accept  = (state_q == IDLE) && op_valid;
    timeout = (state_q == WAIT) && !mem.mem_rvalid && (cnt_q == CNT_LAST);
  end

  lsu_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (mem.mem_rdata),
    .funct3 (funct3_q),
    .off    (off_q),
    .data   (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (op_valid) state_d = op_bad ? FIN : REQ;
      REQ:  if (mem.mem_ready) state_d = store_q ? FIN : WAIT;
      WAIT: begin
        if (mem.mem_rvalid) state_d = WB;
        else if (timeout)   state_d = FIN;
      end
      WB:      state_d = IDLE;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q   <= 1'b0;
      funct3_q  <= '0;
      off_q     <= '0;
      rd_q      <= '0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      wb_data_q <= '0;
    end else begin
      if (accept) begin
        store_q  <= op_store;
        funct3_q <= op_funct3;
        off_q    <= op_addr[1:0];
        rd_q     <= op_rd;
        err_q    <= op_bad;
        addr_q   <= {op_addr[XLEN-1:2], 2'b00};
        wstrb_q  <= op_store ? lane.wstrb : '0;
        wdata_q  <= op_store ? lane.wdata : '0;
      end
      if (state_q == REQ)       cnt_q <= '0;
      else if (state_q == WAIT) cnt_q <= cnt_q + 1'b1;
      if (timeout) err_q <= 1'b1;
      if ((state_q == WAIT) && mem.mem_rvalid) wb_data_q <= ld_data;
    end
  end

  always_comb begin
    op_ready      = (state_q == IDLE);
    mem.mem_req   = (state_q == REQ);
    mem.mem_we    = store_q;
    mem.mem_addr  = addr_q;
    mem.mem_wstrb = wstrb_q;
    mem.mem_wdata = wdata_q;
    done          = (state_q == WB) || (state_q == FIN);
    err           = (state_q == FIN) && err_q;
    wb_en         = (state_q == WB) && (rd_q != 5'd0);
    wb_reg        = rd_q;
    wb_data       = wb_data_q;
  end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with MAX_WAIT=4; memory responses are
// driven by hand per test.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid, op_ready, op_store;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr, op_wdata;
  logic [4:0]  op_rd;
  logic        done, err, wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  lsu_if #(.XLEN(32)) mem_bus ();

  lsu #(.XLEN(32), .MAX_WAIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_store  (op_store),
    .op_funct3 (op_funct3),
    .op_addr   (op_addr),
    .op_wdata  (op_wdata),
    .op_rd     (op_rd),
    .done      (done),
    .err       (err),
    .mem       (mem_bus),
    .wb_en     (wb_en),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op for a single cycle; returns 1ns after the accepting edge.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    op_valid  = 1'b1;
    op_store  = st;
    op_funct3 = f3;
    op_addr   = a;
    op_wdata  = wd;
    op_rd     = rd;
    tick();
    op_valid  = 1'b0;
  endtask

  // Load with zero-wait response on the first WAIT cycle, then check writeback.
  task automatic load_fast(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input logic [31:0] exp_data);
    mem_bus.mem_ready = 1'b1;
    issue(1'b0, f3, a, 32'h0, rd);
    check({tag, "_req"}, {31'b0, mem_bus.mem_req}, 32'd1);
    tick();
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata  = rdata;
    tick();
    mem_bus.mem_rvalid = 1'b0;
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_wb_en"}, {31'b0, wb_en}, {31'b0, (rd != 5'd0)});
    if (rd != 5'd0) check({tag, "_wb_data"}, wb_data, exp_data);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    op_valid = 1'b0; op_store = 1'b0; op_funct3 = '0;
    op_addr = '0; op_wdata = '0; op_rd = '0;
    mem_bus.mem_ready = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
    tick();
    check("rst_op_ready", {31'b0, op_ready}, 32'd1);
    check("rst_mem_req", {31'b0, mem_bus.mem_req}, 32'd0);
    check("rst_done", {30'b0, done, err}, 32'd0);
    check("rst_wb_en", {31'b0, wb_en}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_mem_addr", mem_bus.mem_addr, 32'd0);
    check("rst_wstrb", {28'b0, mem_bus.mem_wstrb}, 32'd0);
    rst_n = 1'b1;
    tick();

    // SB to 0x103: top lane, byte replicated, done on third cycle.
    mem_bus.mem_ready = 1'b1;
    issue(1'b1, 3'b000, 32'h0000_0103, 32'hAABB_CCDD, 5'd0);
    check("sb_req", {31'b0, mem_bus.mem_req}, 32'd1);
    check("sb_we", {31'b0, mem_bus.mem_we}, 32'd1);
    check("sb_addr", mem_bus.mem_addr, 32'h0000_0100);
    check("sb_wstrb", {28'b0, mem_bus.mem_wstrb}, 32'h8);
    check("sb_wdata", mem_bus.mem_wdata, 32'hDDDD_DDDD);
    check("sb_done_early", {31'b0, done}, 32'd0);
    tick();
    check("sb_done", {31'b0, done}, 32'd1);
    check("sb_err", {31'b0, err}, 32'd0);
    check("sb_no_wb", {31'b0, wb_en}, 32'd0);
    tick();
    check("sb_idle", {31'b0, op_ready}, 32'd1);
    check("sb_done_pulse", {31'b0, done}, 32'd0);

    // SH to 0x102 with memory stalling two cycles: request must hold.
    mem_bus.mem_ready = 1'b0;
    issue(1'b1, 3'b001, 32'h0000_0102, 32'h1122_3344, 5'd0);
    tick();
    tick();
    check("sh_hold_req", {31'b0, mem_bus.mem_req}, 32'd1);
    check("sh_wstrb", {28'b0, mem_bus.mem_wstrb}, 32'hC);
    check("sh_wdata", mem_bus.mem_wdata, 32'h3344_3344);
    check("sh_hold_done", {31'b0, done}, 32'd0);
    mem_bus.mem_ready = 1'b1;
    tick();
    check("sh_done", {30'b0, done, err}, 32'd2);
    tick();

    // LB at 0x102, rvalid two cycles after the handshake.
    issue(1'b0, 3'b000, 32'h0000_0102, 32'hFFFF_FFFF, 5'd5);
    check("lb_wstrb", {28'b0, mem_bus.mem_wstrb}, 32'd0);
    check("lb_we", {31'b0, mem_bus.mem_we}, 32'd0);
    check("lb_addr", mem_bus.mem_addr, 32'h0000_0100);
    tick();
    check("lb_wait1_done", {31'b0, done}, 32'd0);
    tick();
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata  = 32'h12F0_3456;
    tick();
    mem_bus.mem_rvalid = 1'b0;
    check("lb_wb_en", {31'b0, wb_en}, 32'd1);
    check("lb_wb_reg", {27'b0, wb_reg}, 32'd5);
    check("lb_wb_data", wb_data, 32'hFFFF_FFF0);
    check("lb_done", {30'b0, done, err}, 32'd2);
    tick();
    check("lb_wb_pulse", {31'b0, wb_en}, 32'd0);

    load_fast("lbu", 3'b100, 32'h0000_0102, 5'd6, 32'h12F0_3456, 32'h0000_00F0);
    load_fast("lh_x0", 3'b001, 32'h0000_0004, 5'd0, 32'h8000_7FFF, 32'h0);
    load_fast("lh_hi", 3'b001, 32'h0000_0006, 5'd7, 32'h8000_7FFF, 32'hFFFF_8000);
    load_fast("lhu_hi", 3'b101, 32'h0000_0006, 5'd8, 32'h8000_7FFF, 32'h0000_8000);
    load_fast("lw", 3'b010, 32'h0000_0200, 5'd1, 32'hCAFE_BABE, 32'hCAFE_BABE);

    // Misaligned LW and illegal funct3: immediate error, no request.
    issue(1'b0, 3'b010, 32'h0000_0202, 32'h0, 5'd2);
    check("lw_mis_req", {31'b0, mem_bus.mem_req}, 32'd0);
    check("lw_mis_done", {30'b0, done, err}, 32'd3);
    check("lw_mis_wb", {31'b0, wb_en}, 32'd0);
    tick();
    check("lw_mis_pulse", {30'b0, done, err}, 32'd0);
    issue(1'b0, 3'b011, 32'h0000_0200, 32'h0, 5'd2);
    check("ld_f3_3_req", {31'b0, mem_bus.mem_req}, 32'd0);
    check("ld_f3_3_done", {30'b0, done, err}, 32'd3);
    tick();
    issue(1'b1, 3'b100, 32'h0000_0200, 32'h0, 5'd0);
    check("st_f3_4_done", {30'b0, done, err}, 32'd3);
    tick();

    // LW timeout: four WAIT cycles, then error, then next op accepted.
    issue(1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd3);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("to_wait_done", {31'b0, done}, 32'd0);
      check("to_wait_req", {31'b0, mem_bus.mem_req}, 32'd0);
      tick();
    end
    check("to_done", {30'b0, done, err}, 32'd3);
    check("to_no_wb", {31'b0, wb_en}, 32'd0);
    check("to_busy", {31'b0, op_ready}, 32'd0);
    tick();
    check("to_ready", {31'b0, op_ready}, 32'd1);
    issue(1'b1, 3'b010, 32'h0000_0400, 32'h1234_5678, 5'd0);
    check("sw_wstrb", {28'b0, mem_bus.mem_wstrb}, 32'hF);
    check("sw_wdata", mem_bus.mem_wdata, 32'h1234_5678);
    tick();
    check("sw_done", {30'b0, done, err}, 32'd2);
    tick();

    // Reset while waiting for a load response.
    issue(1'b0, 3'b010, 32'h0000_0500, 32'h0, 5'd9);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_req", {31'b0, mem_bus.mem_req}, 32'd0);
    check("rst_mid_ready", {31'b0, op_ready}, 32'd1);
    check("rst_mid_wb", {31'b0, wb_en}, 32'd0);
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata  = 32'h5555_AAAA;
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_late_rvalid_wb", {31'b0, wb_en}, 32'd0);
    check("rst_late_rvalid_done", {31'b0, done}, 32'd0);
    tick();
    check("rst_late_ready", {31'b0, op_ready}, 32'd1);
    check("rst_late_wb_data", wb_data, 32'd0);
    mem_bus.mem_rvalid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
